// File: rtl/ram_output_argmax.sv
// ram_output_argmax: output-layer RAM with a registered read address and an argmax scan engine.
// Define RAM_OUT_SIGNED_CMP_EN to compare entries as two's-complement values instead of unsigned.
module ram_output_argmax #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_OUT    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] max_idx,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic                  wr_rej
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_OUT - 1);
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, max_idx_q;
  logic [DATA_WIDTH-1:0] max_val_q, rd_val;
  logic                  done_q, wr_rej_q, gt, take;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  assign rd_val = mem[addr_q];
`ifdef RAM_OUT_SIGNED_CMP_EN
  assign gt = $signed(rd_val) > $signed(max_val_q);
`else
  assign gt = rd_val > max_val_q;
`endif
  // index 0 is always the first compare, so it seeds the result unconditionally
  assign take = (addr_q == '0) || gt;
  always_ff @(posedge clk)
    if (we && state_q == IDLE) mem[addr] <= data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
      done_q    <= 1'b0;
      wr_rej_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wr_rej_q <= 1'b0;
      if (state_q == IDLE) begin
        addr_q <= start ? '0 : addr;
        if (start) state_q <= SCAN;
      end else begin
        wr_rej_q <= we;
        if (take) begin
          max_val_q <= rd_val;
          max_idx_q <= addr_q;
        end
        if (addr_q == LAST) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else addr_q <= addr_q + 1'b1;
      end
    end
  end
  assign q       = rd_val;
  assign busy    = state_q == SCAN;
  assign done    = done_q;
  assign wr_rej  = wr_rej_q;
  assign max_idx = max_idx_q;
  assign max_val = max_val_q;
endmodule

// File: tb/tb_ram_output_argmax.sv
// tb_ram_output_argmax: randomized and directed checks of ram_output_argmax against an array-based argmax model.
module tb_ram_output_argmax;
  localparam int DW = 8, AW = 4, N = 10;
  logic clk = 0, rst_n = 0, we = 0, start = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] q, max_val;
  logic [AW-1:0] max_idx;
  logic busy, done, wr_rej;
  int total = 0, bad = 0;
  logic [DW-1:0] mdl [2**AW];

  ram_output_argmax #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .q(q),
    .start(start), .busy(busy), .done(done), .max_idx(max_idx),
    .max_val(max_val), .wr_rej(wr_rej));

  always #5 clk = ~clk;

  function automatic bit greater(logic [DW-1:0] a, logic [DW-1:0] b);
`ifdef RAM_OUT_SIGNED_CMP_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  task automatic argmax(output int idx, output logic [DW-1:0] val);
    idx = 0;
    val = mdl[0];
    for (int i = 1; i < N; i++)
      if (greater(mdl[i], val)) begin
        idx = i;
        val = mdl[i];
      end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1; addr = AW'(a); data = d; mdl[a] = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd(input int a, input string tag);
    @(negedge clk);
    addr = AW'(a);
    @(negedge clk);
    check(tag, q, mdl[a]);
  endtask

  // wr_k: drive a rejected write after scan edge k; st_k: extra start after edge k; wr0: write with start
  task automatic scan(input string tag, input int wr_k, input int st_k, input bit wr0);
    int ei;
    logic [DW-1:0] ev;
    bit seen;
    @(negedge clk);
    start = 1;
    if (wr0) begin
      we = 1; addr = '0; data = 8'hFE; mdl[0] = 8'hFE;
    end
    argmax(ei, ev);
    @(negedge clk);
    start = 0; we = 0;
    check({tag, "_busy0"}, busy, 1);
    seen = 0;
    for (int k = 1; k <= 3 * N && !seen; k++) begin
      @(negedge clk);
      we = 0; start = 0;
      if (done) begin
        seen = 1;
        check({tag, "_lat"}, k, N);
        check({tag, "_busy_end"}, busy, 0);
      end else if (busy !== 1'b1) check({tag, "_busy"}, busy, 1);
      check({tag, "_wrrej"}, wr_rej, (wr_k > 0 && k == wr_k + 1) ? 1 : 0);
      if (k == wr_k) begin
        we = 1; addr = 2; data = 8'h77;
      end
      if (k == st_k) start = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_idx"}, max_idx, ei);
    check({tag, "_val"}, max_val, ev);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_hold"}, max_val, ev);
  endtask

  initial begin
    logic [DW-1:0] v1 [N] = '{8'h03, 8'h11, 8'h07, 8'h42, 8'h05, 8'h42, 8'h00, 8'h01, 8'h02, 8'h09};
    logic [DW-1:0] v2 [N] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'hF0};
    int ei;
    logic [DW-1:0] ev;
    bit saw_done;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrrej", wr_rej, 0);
    check("rst_idx", max_idx, 0);
    check("rst_val", max_val, 0);
    rst_n = 1;
    for (int i = 0; i < 2**AW; i++) wr(i, DW'($urandom));
    rd(7, "rd7");
    @(negedge clk);
    we = 1; addr = 5; data = 8'hA5; mdl[5] = 8'hA5;
    @(negedge clk);
    we = 0;
    check("rdw_new", q, 8'hA5);

    for (int i = 0; i < N; i++) wr(i, v1[i]);
    scan("tie", 0, 0, 0);
    check("tie_idx3", max_idx, 3);
    check("tie_val42", max_val, 8'h42);

    for (int i = 0; i < N; i++) wr(i, v2[i]);
    scan("sgn", 0, 0, 0);
`ifdef RAM_OUT_SIGNED_CMP_EN
    check("sgn_idx_c", max_idx, 8);
    check("sgn_val_c", max_val, 8'h5A);
`else
    check("sgn_idx_c", max_idx, 9);
    check("sgn_val_c", max_val, 8'hF0);
`endif

    scan("rej", 2, 0, 0);
    rd(2, "rej_ram2");

    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_idx", max_idx, 0);
    check("mid_val", max_val, 0);
    @(negedge clk);
    rst_n = 1;
    saw_done = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("mid_no_done", saw_done, 0);
    rd(3, "mid_ram3");

    for (int i = 1; i < N; i++) wr(i, DW'($urandom_range(0, 16)));
    scan("sw", 0, 3, 1);
    rd(0, "sw_ram0");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        wr(i, (t % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom));
      argmax(ei, ev);
      scan($sformatf("rnd%0d", t), 0, 0, 0);
      rd($urandom_range(0, 2**AW - 1), $sformatf("rnd%0d_rd", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
